// File: rtl/test1_map_scanner_pkg.sv
// Shared types and constants for the snake-game raster scanner.
// Holds the grid geometry, object/FSM encodings and the cell encoder.
package snake_pkg;

    localparam int GRID_W  = 16;
    localparam int GRID_H  = 12;
    localparam int CELLS   = GRID_W * GRID_H;
    localparam int CELL_AW = 8;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        BODY   = 3'd1,
        HEAD   = 3'd2,
        APPLE  = 3'd3,
        BORDER = 3'd4
    } obj_t;

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        WAIT = 2'd1,
        OVER = 2'd2
    } state_t;

    // Row-major linear index into the frame store.
    function automatic logic [CELL_AW-1:0] cell_addr(input logic [3:0] x, input logic [3:0] y);
        return CELL_AW'(y) * CELL_AW'(GRID_W) + CELL_AW'(x);
    endfunction

    // Border outranks head, head outranks body, body outranks apple.
    function automatic obj_t encode_obj(input logic border, input logic head,
                                        input logic body, input logic apple);
        if (border)    return BORDER;
        else if (head) return HEAD;
        else if (body) return BODY;
        else if (apple) return APPLE;
        else           return EMPTY;
    endfunction

endpackage

// File: rtl/test1_map_scanner_if.sv
// Scanner bus: game-logic flags/controls in, draw request and cell coordinates out.
// master = scanner side, slave = game logic + display driver side.
interface test1_map_scanner_if;

    logic       snakeBody;
    logic       snakeHead;
    logic       apple;
    logic       border;
    logic       mode_pb;
    logic       GameOver;
    logic       cmd_done;
    logic       enable_loop;
    logic       diff;
    logic       init_cycle;
    logic       en_update;
    logic       sync_reset;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] obj_code;

    modport master (
        input  snakeBody, snakeHead, apple, border, mode_pb, GameOver, cmd_done,
        output enable_loop, diff, init_cycle, en_update, sync_reset, x, y, obj_code
    );

    modport slave (
        output snakeBody, snakeHead, apple, border, mode_pb, GameOver, cmd_done,
        input  enable_loop, diff, init_cycle, en_update, sync_reset, x, y, obj_code
    );

endinterface

// File: rtl/test1_map_scanner_frame_store.sv
// Copy of the last drawn frame: one 3-bit code per cell.
// Single write port, asynchronous read, whole-array clear on restart.
module test1_map_scanner_frame_store
    import snake_pkg::*;
(
    input  logic               clk,
    input  logic               nrst,
    input  logic               i_clr,
    input  logic               i_we,
    input  logic [CELL_AW-1:0] i_waddr,
    input  logic [2:0]         i_wdata,
    input  logic [CELL_AW-1:0] i_raddr,
    output logic [2:0]         o_rdata
);

    logic [2:0] r_mem [CELLS];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < CELLS; i++) r_mem[i] <= 3'b000;
        end else if (i_clr) begin
            for (int i = 0; i < CELLS; i++) r_mem[i] <= 3'b000;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/test1_map_scanner.sv
// Raster scanner: walks the 16x12 grid, compares each cell with the last drawn
// frame and hands changed cells to the LCD command engine one at a time.
module test1_map_scanner
    import snake_pkg::*;
(
    input  logic                 clk,
    input  logic                 nrst,
    test1_map_scanner_if.master  bus
);

    localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
    localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_x;
    logic [3:0]           r_y;
    logic                 r_init;
    logic                 r_en_update;
    logic                 r_sync_reset;
    obj_t                 w_obj;
    logic [2:0]           w_code;
    logic [2:0]           w_mem_code;
    logic [CELL_AW-1:0]   w_addr;
    logic                 w_diff;
    logic                 w_advance;
    logic                 w_write;
    logic                 w_restart;

    assign w_obj  = encode_obj(bus.border, bus.snakeHead, bus.snakeBody, bus.apple);
    assign w_code = w_obj;
    assign w_addr = cell_addr(r_x, r_y);
    assign w_diff = r_init | (w_code != w_mem_code);

    test1_map_scanner_frame_store u_frame (
        .clk     (clk),
        .nrst    (nrst),
        .i_clr   (w_restart),
        .i_we    (w_write),
        .i_waddr (w_addr),
        .i_wdata (w_code),
        .i_raddr (w_addr),
        .o_rdata (w_mem_code)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        w_write     = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            SCAN: begin
                if (bus.GameOver) begin
                    w_state_nxt = OVER;
                end else if (w_diff) begin
                    w_write     = 1'b1;
                    w_state_nxt = WAIT;
                end else begin
                    w_advance = 1'b1;
                end
            end
            // A GameOver raised here is picked up by SCAN once the draw completes.
            WAIT: begin
                if (bus.cmd_done) begin
                    w_advance   = 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            OVER: begin
                if (bus.mode_pb) begin
                    w_restart   = 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= SCAN;
            r_x          <= 4'd0;
            r_y          <= 4'd0;
            r_init       <= 1'b1;
            r_en_update  <= 1'b0;
            r_sync_reset <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_en_update  <= w_write;
            r_sync_reset <= w_restart;
            if (w_restart) begin
                r_x    <= 4'd0;
                r_y    <= 4'd0;
                r_init <= 1'b1;
            end else if (w_advance) begin
                if (r_x == X_LAST) begin
                    r_x <= 4'd0;
                    // Wrapping the last cell ends the full-frame pass.
                    if (r_y == Y_LAST) begin
                        r_y    <= 4'd0;
                        r_init <= 1'b0;
                    end else begin
                        r_y <= r_y + 4'd1;
                    end
                end else begin
                    r_x <= r_x + 4'd1;
                end
            end
        end
    end

    assign bus.enable_loop = (r_state == SCAN);
    assign bus.diff        = w_diff;
    assign bus.init_cycle  = r_init;
    assign bus.en_update   = r_en_update;
    assign bus.sync_reset  = r_sync_reset;
    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.obj_code    = w_code;

endmodule

// File: tb/tb_test1_map_scanner.sv
// Scoreboard bench for the map scanner: a cell map drives the flags, a frame
// model predicts every draw, a monitor pops and checks each request.
module tb_test1_map_scanner;
    import snake_pkg::*;

    typedef struct {
        int x;
        int y;
        int code;
    } draw_t;

    logic clk;
    logic nrst;
    test1_map_scanner_if bus ();

    test1_map_scanner dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        tests = 0;
    int        fails = 0;
    int        upd_cnt = 0;
    int        sr_cnt = 0;
    draw_t     q[$];
    int        frm [CELLS];
    logic [3:0] map [CELLS];
    bit        resp_hold = 1'b1;
    bit        pend = 1'b0;
    int        w_cidx;

    // Flags for whatever cell the scanner is currently pointing at.
    assign w_cidx = int'(bus.y) * GRID_W + int'(bus.x);
    assign {bus.border, bus.snakeHead, bus.snakeBody, bus.apple} =
           (w_cidx < CELLS) ? map[w_cidx] : 4'b0000;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int enc(input logic [3:0] f);
        if (f[3]) return 4;
        if (f[2]) return 2;
        if (f[1]) return 1;
        if (f[0]) return 3;
        return 0;
    endfunction

    // Walk one full lap from 'start'; every cell whose code differs from the
    // last drawn one (or was never drawn) yields one draw, in raster order.
    task automatic plan(input int start);
        for (int k = 0; k < CELLS; k++) begin
            int c;
            int e;
            draw_t d;
            c = (start + k) % CELLS;
            e = enc(map[c]);
            if (frm[c] != e) begin
                d.x = c % GRID_W;
                d.y = c / GRID_W;
                d.code = e;
                q.push_back(d);
                frm[c] = e;
            end
        end
    endtask

    function automatic int dut_pos();
        return int'(bus.y) * GRID_W + int'(bus.x);
    endfunction

    // Display driver: answers each request after 0..3 cycles, and sometimes
    // pulses cmd_done when nothing is pending (must be ignored).
    initial begin
        int dly;
        dly = 0;
        bus.cmd_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.cmd_done = 1'b0;
            if (bus.en_update === 1'b1) begin
                pend = 1'b1;
                dly  = $urandom_range(0, 3);
            end
            if (pend) begin
                if (!resp_hold) begin
                    if (dly == 0) begin
                        bus.cmd_done = 1'b1;
                        pend = 1'b0;
                    end else begin
                        dly--;
                    end
                end
            end else if ($urandom_range(0, 7) == 0) begin
                bus.cmd_done = 1'b1;
            end
        end
    end

    // Monitor: every draw request and every SCAN-cycle diff must match the
    // oldest outstanding expected draw.
    always @(posedge clk) begin
        #1;
        if (bus.sync_reset === 1'b1) sr_cnt++;
        if (bus.en_update === 1'b1) begin
            upd_cnt++;
            chk("draw_scan_off", int'(bus.enable_loop), 0);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL draw_unexpected: got draw at (%0d,%0d) code %0d expected none",
                         bus.x, bus.y, bus.obj_code);
            end else begin
                draw_t d;
                d = q.pop_front();
                chk("draw_cell", dut_pos(), d.y * GRID_W + d.x);
                chk("draw_code", int'(bus.obj_code), d.code);
            end
        end else if (bus.enable_loop === 1'b1 && bus.diff === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL diff_unexpected: got diff at (%0d,%0d) expected none",
                         bus.x, bus.y);
            end else begin
                chk("diff_cell", dut_pos(), q[0].y * GRID_W + q[0].x);
                chk("diff_code", int'(bus.obj_code), q[0].code);
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((q.size() != 0 || pend) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_in_budget", int'(n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    // Quiescent scanner must step one cell per cycle, wrapping rows and frame.
    task automatic step_check(input int n, output int pos);
        int p0;
        p0 = dut_pos();
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            chk("step_pos", dut_pos(), (p0 + i) % CELLS);
            chk("step_loop_diff", int'({bus.enable_loop, bus.diff}), 2);
        end
        pos = (p0 + n) % CELLS;
    endtask

    task automatic do_restart(input int sr_exp);
        bus.mode_pb  = 1'b1;
        bus.GameOver = 1'b0;
        for (int i = 0; i < CELLS; i++) frm[i] = -1;
        plan(0);
        @(negedge clk);
        bus.mode_pb = 1'b0;
        chk("restart_sync_reset", int'(bus.sync_reset), 1);
        chk("restart_pos", dut_pos(), 0);
        chk("restart_init", int'(bus.init_cycle), 1);
        wait_idle(1500);
        chk("restart_sr_count", sr_cnt, sr_exp);
        chk("restart_init_drop", int'(bus.init_cycle), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int c;
        int u0;
        int n;
        nrst = 1'b0;
        bus.mode_pb  = 1'b0;
        bus.GameOver = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            map[i] = 4'b0000;
            frm[i] = -1;
        end
        plan(0);

        // Reset state, then a stalled first request.
        repeat (2) @(negedge clk);
        chk("rst_pos", dut_pos(), 0);
        chk("rst_init", int'(bus.init_cycle), 1);
        chk("rst_en_update", int'(bus.en_update), 0);
        chk("rst_sync_reset", int'(bus.sync_reset), 0);
        nrst = 1'b1;
        repeat (5) @(negedge clk);
        chk("stall_upd_count", upd_cnt, 1);
        chk("stall_pos", dut_pos(), 0);
        chk("stall_init", int'(bus.init_cycle), 1);
        chk("stall_loop", int'(bus.enable_loop), 0);

        // First full pass.
        resp_hold = 1'b0;
        wait_idle(1500);
        chk("pass1_upd_count", upd_cnt, CELLS);
        chk("pass1_init_drop", int'(bus.init_cycle), 0);

        // Second pass with no changes, then a head at (4,4).
        step_check(200, p);
        map[4 * GRID_W + 4] = 4'b0100;
        plan(p);
        wait_idle(1500);

        // Random map edits; first round includes a border+head cell.
        for (int r = 0; r < 6; r++) begin
            step_check($urandom_range(3, 40), p);
            if (r == 0) map[2 * GRID_W + 7] = 4'b1100;
            for (int k = 0; k < 12; k++) begin
                c = $urandom_range(0, CELLS - 1);
                map[c] = 4'($urandom_range(0, 15));
            end
            plan(p);
            wait_idle(1500);
        end

        // GameOver together with mode_pb in SCAN: GameOver wins, position holds.
        step_check(7, p);
        bus.GameOver = 1'b1;
        bus.mode_pb  = 1'b1;
        @(negedge clk);
        bus.mode_pb = 1'b0;
        chk("over_pos", dut_pos(), p);
        chk("over_loop", int'(bus.enable_loop), 0);
        chk("over_no_sync", int'(bus.sync_reset), 0);
        repeat (4) @(negedge clk);
        chk("over_hold_pos", dut_pos(), p);
        chk("over_hold_loop", int'(bus.enable_loop), 0);
        chk("over_sr_count", sr_cnt, 0);
        do_restart(1);

        // GameOver raised while waiting for cmd_done: finish draw, step, then stop.
        step_check(9, p);
        c = (p + 5) % CELLS;
        map[c] = (enc(map[c]) == 2) ? 4'b0010 : 4'b0100;
        resp_hold = 1'b1;
        plan(p);
        u0 = upd_cnt;
        n = 0;
        while (upd_cnt == u0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wait_req_seen", int'(n < 400), 1);
        bus.GameOver = 1'b1;
        repeat (3) @(negedge clk);
        chk("wait_hold_pos", dut_pos(), c);
        chk("wait_hold_loop", int'(bus.enable_loop), 0);
        resp_hold = 1'b0;
        n = 0;
        while (pend && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("wait_over_pos", dut_pos(), (c + 1) % CELLS);
        chk("wait_over_loop", int'(bus.enable_loop), 0);
        do_restart(2);

        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
